dm_slot_search: RTL and testbench
=================================

# dm_slot_search

Reverse lookup engine for the data-memory variable region (addresses 72–103). Given a key value, it walks the 32 variable slots through the data-memory read port. It returns the (MuxReg, EntryReg) pointer pair of the first slot holding that value, i.e. the inverse of the forward pointer-to-address mapping (bank 0 → 72–87, bank 1 → 88–103). It sits beside the data memory and shares its read port under control of the processor FSM.

## Interface
- W, default 8: data path width; also the width of MuxReg/EntryReg.
- BASE, default 72: first data-memory address of the variable region.
- SLOTS, default 32: number of slots; two banks of 16.
- Clk  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request a search; honoured only in IDLE.
- Key  in  W  value to find; captured on the accepted Start edge.
- MemAddr  out  10  data-memory read address.
- MemRdEn  out  1  read request; data returns on MemData one cycle later.
- MemData  in  W  data-memory read data.
- Busy  out  1  high in SCAN and DONE.
- Done  out  1  one-cycle completion pulse.
- Found  out  1  search result; held until the next accepted Start.
- MuxReg  out  W  bank of matching slot (0 or 1); zero-extended.
- EntryReg  out  W  entry 0–15 within bank; zero-extended.

## Operation
- FSM states:
  - IDLE: waits for Start.
  - SCAN: issues reads and compares returned data.
  - DONE: pulses Done for one cycle, then returns to IDLE.
- IDLE, Start=1 at an edge:
  - Capture Key.
  - Clear idx, the compare-valid flag, Found, MuxReg and EntryReg.
  - Go to SCAN.
- SCAN read side, while idx < SLOTS:
  - MemRdEn=1 and MemAddr=BASE+idx, both driven combinationally from registered idx.
  - idx increments at each edge.
  - When idx reaches SLOTS, MemRdEn=0.
- SCAN compare side:
  - The compare pipeline register holds cmp_valid and cmp_idx, set from the previous cycle's issue.
  - When cmp_valid=1 and MemData==Key: Found←1, MuxReg←cmp_idx[4], EntryReg←cmp_idx[3:0], go to DONE.
  - When cmp_valid=1, no match, and cmp_idx==SLOTS-1: Found←0 and MuxReg/EntryReg stay 0, go to DONE.
- Duplicate values: the lowest slot index wins. Reads already issued past the match are discarded.
- Start outside IDLE, including the DONE cycle, is ignored. Key changes after capture have no effect.
- Arithmetic: idx and cmp_idx are 6 bits wide. MemAddr = BASE + idx, computed in 10 bits with no wrap (max 103).
- Reset, asynchronous and allowed at any point including mid-scan, forces:
  - state=IDLE;
  - Busy, Done, Found, MemRdEn all 0;
  - MuxReg, EntryReg, MemAddr all 0;
  - all internal registers cleared.

## Timing
- Accepted Start at edge 0.
- Slot k address is presented in the cycle after edge k.
- Slot k data is compared at edge k+2.
- Match at slot k: Done=1 and results valid in the cycle after edge k+2, i.e. latency k+3 cycles from Start.
- Miss: Done in the cycle after edge 33, i.e. latency 34 cycles.
- Busy rises in the cycle after edge 0 and falls together with Done. A new Start can be accepted at the edge ending the Done cycle +1 (first IDLE cycle).
- Results are stable from the Done cycle until the next accepted Start.

## Structure
- Shared package dm_map_pkg holds:
  - DM_VAR_BASE=72, DM_VAR_SLOTS=32, DM_BANK_SIZE=16;
  - typedef enum logic [1:0] {IDLE, SCAN, DONE} srch_state_t.
- The forward mapping block uses the same constants.
- Single module; no sub-module required.

## Test plan
- Memory preloaded with 8'hA5 at 72 only, Key=8'hA5 -> Found=1, MuxReg=0, EntryReg=0, Done 3 cycles after Start.
- 8'h3C at 89, Key=8'h3C -> Found=1, MuxReg=1, EntryReg=1, Done 20 cycles after Start; MemAddr sequence 72..90 observed.
- Key absent from 72–103 (present at 71 and 104) -> Found=0, MuxReg=EntryReg=0, Done 34 cycles after Start; MemAddr never outside 72–103.
- 8'h5A at both 80 and 95, Key=8'h5A -> MuxReg=0, EntryReg=8 (first match wins), Done 11 cycles after Start.
- Start re-pulsed with a different Key while Busy -> ignored; the result matches the original Key; Done pulses exactly once.
- Reset asserted asynchronously mid-scan at idx=10 -> outputs all 0 immediately; Start after release runs a clean full search with correct result.

Source files
------------

// File: rtl/dm_map_pkg.sv
// Shared constants for the data-memory variable region and the slot-search FSM
// state type, used by both the forward mapping and the reverse lookup.
package dm_map_pkg;

    localparam int DM_VAR_BASE  = 72;
    localparam int DM_VAR_SLOTS = 32;
    localparam int DM_BANK_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } srch_state_t;

    // Data-memory address of a variable slot; region never exceeds 10 bits.
    function automatic logic [9:0] slot_addr(input logic [5:0] idx, input int base);
        return 10'(base) + {4'd0, idx};
    endfunction

endpackage

// File: rtl/dm_slot_search_if.sv
// Request/result and data-memory read-port signals of the slot search engine.
interface dm_slot_search_if #(parameter int W = 8);

    logic         Start;
    logic [W-1:0] Key;
    logic [9:0]   MemAddr;
    logic         MemRdEn;
    logic [W-1:0] MemData;
    logic         Busy;
    logic         Done;
    logic         Found;
    logic [W-1:0] MuxReg;
    logic [W-1:0] EntryReg;

    modport master (
        output Start, Key, MemData,
        input  MemAddr, MemRdEn, Busy, Done, Found, MuxReg, EntryReg
    );

    modport slave (
        input  Start, Key, MemData,
        output MemAddr, MemRdEn, Busy, Done, Found, MuxReg, EntryReg
    );

endinterface

// File: rtl/dm_slot_search.sv
// Reverse lookup: walks the 32 variable slots through the data-memory read port
// and returns the (bank, entry) pair of the lowest slot holding the key.
module dm_slot_search
    import dm_map_pkg::*;
#(
    parameter int W     = 8,
    parameter int BASE  = DM_VAR_BASE,
    parameter int SLOTS = DM_VAR_SLOTS
) (
    input  logic              Clk,
    input  logic              Reset,
    dm_slot_search_if.slave   bus
);

    localparam logic [5:0] SLOTS_IDX = 6'(SLOTS);
    localparam logic [5:0] LAST_IDX  = 6'(SLOTS - 1);

    srch_state_t  state_r, state_s;
    logic [W-1:0] key_r, key_s;
    logic [5:0]   idx_r, idx_s;
    logic         cmp_valid_r, cmp_valid_s;
    logic [5:0]   cmp_idx_r, cmp_idx_s;
    logic         found_r, found_s;
    logic         mux_r, mux_s;
    logic [3:0]   entry_r, entry_s;
    logic         issue_s;

    // State and datapath registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r     <= IDLE;
            key_r       <= '0;
            idx_r       <= 6'd0;
            cmp_valid_r <= 1'b0;
            cmp_idx_r   <= 6'd0;
            found_r     <= 1'b0;
            mux_r       <= 1'b0;
            entry_r     <= 4'd0;
        end else begin
            state_r     <= state_s;
            key_r       <= key_s;
            idx_r       <= idx_s;
            cmp_valid_r <= cmp_valid_s;
            cmp_idx_r   <= cmp_idx_s;
            found_r     <= found_s;
            mux_r       <= mux_s;
            entry_r     <= entry_s;
        end
    end

    assign issue_s = (state_r == SCAN) && (idx_r < SLOTS_IDX);

    // Next-state, read issue and compare pipeline.
    always_comb begin
        state_s     = state_r;
        key_s       = key_r;
        idx_s       = idx_r;
        cmp_valid_s = 1'b0;
        cmp_idx_s   = cmp_idx_r;
        found_s     = found_r;
        mux_s       = mux_r;
        entry_s     = entry_r;
        case (state_r)
            IDLE: begin
                if (bus.Start) begin
                    state_s   = SCAN;
                    key_s     = bus.Key;
                    idx_s     = 6'd0;
                    cmp_idx_s = 6'd0;
                    found_s   = 1'b0;
                    mux_s     = 1'b0;
                    entry_s   = 4'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (issue_s) begin
                    idx_s       = idx_r + 6'd1;
                    cmp_valid_s = 1'b1;
                    cmp_idx_s   = idx_r;
                end else begin
                    cmp_valid_s = 1'b0;
                end
                // A hit or the last slot's miss ends the scan; reads in flight are dropped.
                if (cmp_valid_r && (bus.MemData == key_r)) begin
                    state_s     = DONE;
                    cmp_valid_s = 1'b0;
                    found_s     = 1'b1;
                    mux_s       = cmp_idx_r[4];
                    entry_s     = cmp_idx_r[3:0];
                end else if (cmp_valid_r && (cmp_idx_r == LAST_IDX)) begin
                    state_s     = DONE;
                    cmp_valid_s = 1'b0;
                    found_s     = 1'b0;
                end else begin
                    state_s = SCAN;
                end
            end
            DONE: begin
                state_s = IDLE;
                idx_s   = 6'd0;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign bus.MemRdEn  = issue_s;
    assign bus.MemAddr  = issue_s ? slot_addr(idx_r, BASE) : 10'd0;
    assign bus.Busy     = (state_r == SCAN) || (state_r == DONE);
    assign bus.Done     = (state_r == DONE);
    assign bus.Found    = found_r;
    assign bus.MuxReg   = {{(W-1){1'b0}}, mux_r};
    assign bus.EntryReg = {{(W-4){1'b0}}, entry_r};

endmodule

// File: tb/tb_dm_slot_search.sv
// Self-checking bench for dm_slot_search: behavioural data memory with one-cycle
// read latency and a scoreboard of expected search results.
module tb_dm_slot_search;

    logic Clk;
    logic Reset;

    dm_slot_search_if #(.W(8)) bus ();

    dm_slot_search #(.W(8), .BASE(72), .SLOTS(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic       f;
        logic [7:0] m;
        logic [7:0] e;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem [0:1023];
    int         addr_q[$];
    int         vecs;
    int         errs;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (bus.MemRdEn) bus.MemData <= mem[bus.MemAddr];
    end

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    endtask

    // Runs one search; rep_at > 0 re-pulses Start with rep_key before that edge.
    task automatic run_search(input logic [7:0] k, input int rep_at, input logic [7:0] rep_key,
                              output int lat, output int dones, output int amin, output int amax,
                              output logic f, output logic [7:0] m, output logic [7:0] e,
                              output logic busy_at_done);
        lat = -1; dones = 0; amin = 1023; amax = 0;
        f = 1'bx; m = 8'hxx; e = 8'hxx; busy_at_done = 1'b0;
        addr_q.delete();
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Key   = k;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        bus.Key   = ~k;
        for (int c = 1; c <= 45; c++) begin
            if (bus.MemRdEn) begin
                addr_q.push_back(int'(bus.MemAddr));
                if (int'(bus.MemAddr) < amin) amin = int'(bus.MemAddr);
                if (int'(bus.MemAddr) > amax) amax = int'(bus.MemAddr);
            end
            if (c == rep_at) begin
                bus.Start = 1'b1;
                bus.Key   = rep_key;
            end else begin
                bus.Start = 1'b0;
            end
            @(posedge Clk);
            #1;
            if (bus.Done) begin
                dones++;
                if (lat < 0) begin
                    lat = c + 1;
                    f = bus.Found;
                    m = bus.MuxReg;
                    e = bus.EntryReg;
                    busy_at_done = bus.Busy;
                end
            end
        end
        bus.Start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.Start = 1'b0;
        bus.Key = 8'h00;
        bus.MemData = 8'h00;
        clear_mem();
        repeat (3) @(posedge Clk);
        #1;
        vecs++;
        if ({bus.Busy, bus.Done, bus.Found, bus.MemRdEn} !== 4'b0000) begin
            errs++;
            $display("FAIL reset_flags got %b want 0000", {bus.Busy, bus.Done, bus.Found, bus.MemRdEn});
        end
        vecs++;
        if ({bus.MuxReg, bus.EntryReg, bus.MemAddr} !== 26'd0) begin
            errs++;
            $display("FAIL reset_regs got mux=%0d entry=%0d addr=%0d want 0", bus.MuxReg, bus.EntryReg, bus.MemAddr);
        end
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        vecs++;
        if (bus.Busy !== 1'b0) begin
            errs++;
            $display("FAIL idle_busy got %b want 0", bus.Busy);
        end
    endtask

    // Common scoreboard comparison for a finished search.
    task automatic test_search(input string name, input logic [7:0] k, input int rep_at,
                               input logic [7:0] rep_key, input exp_t ex,
                               output int amin, output int amax);
        int lat, dones;
        logic f, busy_d;
        logic [7:0] m, e;
        exp_t got_exp;
        sb.push_back(ex);
        run_search(k, rep_at, rep_key, lat, dones, amin, amax, f, m, e, busy_d);
        got_exp = sb.pop_front();
        vecs++;
        if (lat < 0) begin
            errs++;
            $display("FAIL %s_timeout got no Done want Done at latency %0d", name, got_exp.lat);
        end else if (lat !== got_exp.lat) begin
            errs++;
            $display("FAIL %s_latency got %0d want %0d", name, lat, got_exp.lat);
        end
        vecs++;
        if ({f, m, e} !== {got_exp.f, got_exp.m, got_exp.e}) begin
            errs++;
            $display("FAIL %s_result got found=%b mux=%0d entry=%0d want found=%b mux=%0d entry=%0d",
                     name, f, m, e, got_exp.f, got_exp.m, got_exp.e);
        end
        vecs++;
        if (dones !== 1) begin
            errs++;
            $display("FAIL %s_done_count got %0d want 1", name, dones);
        end
        vecs++;
        if (busy_d !== 1'b1 || bus.Busy !== 1'b0) begin
            errs++;
            $display("FAIL %s_busy got done=%b idle=%b want 1 0", name, busy_d, bus.Busy);
        end
        vecs++;
        if ({bus.Found, bus.MuxReg, bus.EntryReg} !== {got_exp.f, got_exp.m, got_exp.e}) begin
            errs++;
            $display("FAIL %s_held got found=%b mux=%0d entry=%0d want found=%b mux=%0d entry=%0d",
                     name, bus.Found, bus.MuxReg, bus.EntryReg, got_exp.f, got_exp.m, got_exp.e);
        end
    endtask

    task automatic test_first_slot();
        int amin, amax;
        clear_mem();
        mem[72] = 8'hA5;
        test_search("slot0", 8'hA5, 0, 8'h00, '{1'b1, 8'd0, 8'd0, 3}, amin, amax);
    endtask

    task automatic test_bank1();
        int amin, amax;
        bit seq_ok;
        clear_mem();
        mem[89] = 8'h3C;
        test_search("bank1", 8'h3C, 0, 8'h00, '{1'b1, 8'd1, 8'd1, 20}, amin, amax);
        seq_ok = (addr_q.size() == 19);
        for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != 72 + i) seq_ok = 1'b0;
        vecs++;
        if (!seq_ok) begin
            errs++;
            $display("FAIL bank1_addr_seq got %0d reads %0d..%0d want 19 reads 72..90",
                     addr_q.size(), amin, amax);
        end
    endtask

    task automatic test_miss();
        int amin, amax;
        clear_mem();
        mem[71]  = 8'h99;
        mem[104] = 8'h99;
        test_search("miss", 8'h99, 0, 8'h00, '{1'b0, 8'd0, 8'd0, 34}, amin, amax);
        vecs++;
        if (amin !== 72 || amax !== 103 || addr_q.size() !== 32) begin
            errs++;
            $display("FAIL miss_addr_range got %0d reads %0d..%0d want 32 reads 72..103",
                     addr_q.size(), amin, amax);
        end
    endtask

    task automatic test_duplicate();
        int amin, amax;
        clear_mem();
        mem[80] = 8'h5A;
        mem[95] = 8'h5A;
        test_search("dup", 8'h5A, 0, 8'h00, '{1'b1, 8'd0, 8'd8, 11}, amin, amax);
    endtask

    task automatic test_restart_ignored();
        int amin, amax;
        clear_mem();
        mem[100] = 8'h11;
        mem[75]  = 8'h22;
        test_search("restart", 8'h11, 5, 8'h22, '{1'b1, 8'd1, 8'd12, 31}, amin, amax);
    endtask

    task automatic test_reset_midscan();
        int amin, amax;
        clear_mem();
        mem[95] = 8'h77;
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Key   = 8'h77;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        vecs++;
        if (bus.MemAddr !== 10'd82 || bus.MemRdEn !== 1'b1) begin
            errs++;
            $display("FAIL midscan_addr got %0d en=%b want 82 en=1", bus.MemAddr, bus.MemRdEn);
        end
        #2;
        Reset = 1'b1;
        #1;
        vecs++;
        if ({bus.Busy, bus.Done, bus.Found, bus.MemRdEn, bus.MuxReg, bus.EntryReg, bus.MemAddr} !== 30'd0) begin
            errs++;
            $display("FAIL midscan_reset got busy=%b done=%b found=%b en=%b mux=%0d entry=%0d addr=%0d want all 0",
                     bus.Busy, bus.Done, bus.Found, bus.MemRdEn, bus.MuxReg, bus.EntryReg, bus.MemAddr);
        end
        @(negedge Clk);
        Reset = 1'b0;
        clear_mem();
        mem[89] = 8'h3C;
        test_search("post_reset", 8'h3C, 0, 8'h00, '{1'b1, 8'd1, 8'd1, 20}, amin, amax);
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_first_slot();
        test_bank1();
        test_miss();
        test_duplicate();
        test_restart_ignored();
        test_reset_midscan();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
